lz77_decoder: RTL and testbench
===============================

// Module: lz77_decoder
// PURPOSE
//  Downstream companion of the LZ77 encoder: consumes (offset, match_len, char_nxt) codes and rebuilds the original stream.
//  Output is one character per cycle, from a shift-register search window mirroring the encoder's (index 0 = newest char).
//  END_CHAR in char_nxt terminates the stream and raises finish.
// PARAMETERS
//  DATA_W       8      character width (encoder emits 4-bit symbols zero-extended into 8 bits)
//  SEARCH_DEPTH 30     search-window entries; legal offset 0..SEARCH_DEPTH-1
//  MAX_MATCH    24     largest legal match_len
//  END_CHAR     8'h24  end-of-stream marker ('$')
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-high
//  code_valid in   1       code fields valid
//  code_ready out  1       decoder can accept a code
//  offset     in   5       window index of first match char
//  match_len  in   5       chars to copy (0 = literal only)
//  char_nxt   in   DATA_W  literal following the match
//  char_out   out  DATA_W  decoded character
//  out_valid  out  1       char_out valid this cycle
//  finish     out  1       END_CHAR decoded; sticky until reset
//  code_err   out  1       (LZ77_DEC_CHECK_EN only) illegal code seen; sticky
// BEHAVIOUR
//  - Reset (async): state IDLE; code_ready=1; out_valid=0; char_out=0; finish=0; code_err=0; window all zero; hist_cnt=0.
//  - Handshake: a code is accepted on a rising edge with code_valid & code_ready. Fields are latched; upstream holds them while ready=0.
//  - FSM: IDLE -> COPY if match_len>0, else LIT. COPY runs L=match_len cycles, then goes to LIT. LIT -> IDLE, or DONE if char_nxt==END_CHAR.
//  - code_ready = (state==IDLE). DONE is absorbing until reset, with code_ready=0.
//  - COPY edge: char_out<=win[offset]; out_valid<=1. Window shifts win[i]<=win[i-1], win[0]<=win[offset].
//    Offset stays constant over the copy; overlapping copies (L > offset+1) fall out of the shift naturally.
//  - LIT edge, char_nxt!=END_CHAR: char_out<=char_nxt; out_valid<=1; window shifts char_nxt in.
//  - LIT edge, char_nxt==END_CHAR: out_valid<=0; finish<=1; no shift; END_CHAR is never emitted.
//  - Any other edge: out_valid<=0; char_out holds.
//  - Timing: accept at edge E. Chars appear after edges E+1..E+L+1, on consecutive cycles with no bubbles.
//    code_ready returns high together with the literal (after E+L+1). Cost per code is L+2 cycles.
//  - hist_cnt: chars written into the window, saturating at SEARCH_DEPTH.
//  - Out-of-range input: offset>=SEARCH_DEPTH reads win[SEARCH_DEPTH-1]. match_len>MAX_MATCH is still copied L times.
//    Both are undefined stream content, but the FSM must not lock up.
//  - code_valid while code_ready=0: ignored, no state change.
//  - Reset asserted mid-COPY: outputs clear immediately; the next code decodes against an all-zero window.
// CONFIGURATION
//  LZ77_DEC_CHECK_EN defined:
//   - Adds code_err, which is set and sticky on acceptance of any code with offset>=SEARCH_DEPTH,
//     match_len>MAX_MATCH, or match_len>0 with offset>=hist_cnt. Decoding proceeds regardless.
//  LZ77_DEC_CHECK_EN undefined: no code_err port and no hist_cnt checking logic. hist_cnt may be removed.
// TESTING
//  1. Reset, then code (0,0,8'h03) -> out_valid=1 for 1 cycle, char_out=03, 2 cycles after accept; code_ready=1 with it.
//  2. Literals 01,02,03, then code (2,3,8'h04) -> stream 01 02 03 01 02 03 04, no bubbles within the code.
//  3. Overlap: literal 05, then (0,5,8'h06) -> 05 05 05 05 05 05 06.
//  4. (0,0,8'h24) after data -> finish=1, out_valid=0, code_ready=0. Later codes ignored until reset.
//  5. Reset during a 24-char copy -> out_valid=0 and finish=0 at once. Code (0,0,8'h07) then yields 07.
//  6. With LZ77_DEC_CHECK_EN: first code (3,2,8'h01) -> code_err=1, sticky. (31,1,x) also flags. Legal streams keep code_err=0.

Source files
------------

// File: rtl/lz77_decoder_if.sv
// Code-in / character-out bus of the LZ77 decoder.
// code_err exists only when LZ77_DEC_CHECK_EN is defined.
interface lz77_decoder_if #(
    parameter int unsigned DATA_W = 8
);
    logic              code_valid;
    logic              code_ready;
    logic [4:0]        offset;
    logic [4:0]        match_len;
    logic [DATA_W-1:0] char_nxt;
    logic [DATA_W-1:0] char_out;
    logic              out_valid;
    logic              finish;
`ifdef LZ77_DEC_CHECK_EN
    logic              code_err;
`endif

    modport master (
        output code_valid, offset, match_len, char_nxt,
`ifdef LZ77_DEC_CHECK_EN
        input  code_err,
`endif
        input  code_ready, char_out, out_valid, finish
    );

    modport slave (
        input  code_valid, offset, match_len, char_nxt,
`ifdef LZ77_DEC_CHECK_EN
        output code_err,
`endif
        output code_ready, char_out, out_valid, finish
    );
endinterface

// File: rtl/lz77_decoder.sv
// LZ77 decoder: expands (offset, match_len, char_nxt) codes into one char per cycle.
// Optional code legality checking is enabled by defining LZ77_DEC_CHECK_EN.
module lz77_decoder #(
    parameter int unsigned       DATA_W       = 8,
    parameter int unsigned       SEARCH_DEPTH = 30,
    parameter int unsigned       MAX_MATCH    = 24,
    parameter logic [DATA_W-1:0] END_CHAR     = 8'h24
) (
    input  logic          clk,
    input  logic          reset,
    lz77_decoder_if.slave dec
);
    localparam logic [4:0] LAST_IDX = 5'(SEARCH_DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StCopy, StLit, StDone} state_e;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [4:0]        r_off;
    logic [4:0]        r_cnt;
    logic [DATA_W-1:0] r_char;
    logic [DATA_W-1:0] r_char_out;
    logic              r_out_valid;
    logic              r_finish;
    logic [DATA_W-1:0] r_win [SEARCH_DEPTH];

    logic              w_accept;
    logic              w_is_end;
    logic              w_shift;
    logic [4:0]        w_rd_idx;
    logic [DATA_W-1:0] w_rd_char;
    logic [DATA_W-1:0] w_shift_char;

    assign w_accept  = dec.code_valid && (r_state == StIdle);
    assign w_is_end  = (r_char == END_CHAR);
    // Out-of-range offsets clamp to the oldest window entry.
    assign w_rd_idx  = (r_off > LAST_IDX) ? LAST_IDX : r_off;
    assign w_rd_char = r_win[w_rd_idx];

    assign dec.code_ready = (r_state == StIdle);
    assign dec.char_out   = r_char_out;
    assign dec.out_valid  = r_out_valid;
    assign dec.finish     = r_finish;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shift      = 1'b0;
        w_shift_char = w_rd_char;
        case (r_state)
            StIdle: begin
                if (dec.code_valid) begin
                    w_state_nxt = (dec.match_len != 5'd0) ? StCopy : StLit;
                end
            end
            StCopy: begin
                w_shift = 1'b1;
                if (r_cnt == 5'd1) begin
                    w_state_nxt = StLit;
                end
            end
            StLit: begin
                if (w_is_end) begin
                    w_state_nxt = StDone;
                end else begin
                    w_shift      = 1'b1;
                    w_shift_char = r_char;
                    w_state_nxt  = StIdle;
                end
            end
            default: w_state_nxt = StDone;
        endcase
    end

    // Every emitted character is also the one shifted into the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_off       <= '0;
            r_cnt       <= '0;
            r_char      <= '0;
            r_char_out  <= '0;
            r_out_valid <= 1'b0;
            r_finish    <= 1'b0;
        end else begin
            r_out_valid <= w_shift;
            if (w_shift) begin
                r_char_out <= w_shift_char;
            end
            if (w_accept) begin
                r_off  <= dec.offset;
                r_cnt  <= dec.match_len;
                r_char <= dec.char_nxt;
            end else if (r_state == StCopy) begin
                r_cnt <= r_cnt - 5'd1;
            end
            if ((r_state == StLit) && w_is_end) begin
                r_finish <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SEARCH_DEPTH; i++) begin
                r_win[i] <= '0;
            end
        end else if (w_shift) begin
            r_win[0] <= w_shift_char;
            for (int i = 1; i < SEARCH_DEPTH; i++) begin
                r_win[i] <= r_win[i-1];
            end
        end
    end

`ifdef LZ77_DEC_CHECK_EN
    localparam int unsigned       HIST_W   = $clog2(SEARCH_DEPTH + 1);
    localparam logic [HIST_W-1:0] HIST_MAX = HIST_W'(SEARCH_DEPTH);
    localparam logic [4:0]        MAX_LEN  = 5'(MAX_MATCH);

    logic [HIST_W-1:0] r_hist_cnt;
    logic              r_code_err;
    logic              w_bad_code;

    // A match may only reference characters that have actually been written.
    assign w_bad_code = (dec.offset > LAST_IDX) || (dec.match_len > MAX_LEN) ||
                        ((dec.match_len != 5'd0) && (HIST_W'(dec.offset) >= r_hist_cnt));
    assign dec.code_err = r_code_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist_cnt <= '0;
            r_code_err <= 1'b0;
        end else begin
            if (w_shift && (r_hist_cnt != HIST_MAX)) begin
                r_hist_cnt <= r_hist_cnt + 1'b1;
            end
            if (w_accept && w_bad_code) begin
                r_code_err <= 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_lz77_decoder.sv
// Self-checking bench for lz77_decoder: fixed vectors, hand-written corner cases and a
// randomized code stream checked against a back-reference history model.
module tb_lz77_decoder;
    localparam int unsigned D      = 30;
    localparam logic [7:0]  END_CH = 8'h24;

    typedef struct packed {
        logic [4:0]  off;
        logic [4:0]  len;
        logic [7:0]  ch;
        logic [3:0]  n;
        logic [63:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    lz77_decoder_if #(.DATA_W(8)) bus ();

    lz77_decoder #(
        .DATA_W      (8),
        .SEARCH_DEPTH(30),
        .MAX_MATCH   (24),
        .END_CHAR    (8'h24)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .dec  (bus.slave)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] mh[$];
    vec_t       vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        mh = {};
        repeat (D) mh.push_back(8'h00);
        got_q = {};
        exp_q = {};
    endtask

    // Reference: window index i is the i-th most recent character of the decoded history.
    task automatic model_code(input logic [4:0] off, input logic [4:0] len, input logic [7:0] ch);
        int         idx;
        logic [7:0] c;
        idx = (int'(off) > D - 1) ? D - 1 : int'(off);
        for (int k = 0; k < int'(len); k++) begin
            c = mh[mh.size() - 1 - idx];
            mh.push_back(c);
            exp_q.push_back(c);
        end
        if (ch != END_CH) begin
            mh.push_back(ch);
            exp_q.push_back(ch);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.code_valid = 1'b0;
        bus.offset = '0;
        bus.match_len = '0;
        bus.char_nxt = '0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_char_out", 32'(bus.char_out), 32'd0);
        check("rst_finish", 32'(bus.finish), 32'd0);
        check("rst_code_ready", 32'(bus.code_ready), 32'd1);
`ifdef LZ77_DEC_CHECK_EN
        check("rst_code_err", 32'(bus.code_err), 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.code_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.code_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: code_ready got 0 after %0d cycles, expected 1", n);
        end
    endtask

    // Sends one code and collects its output cycles; noise drives junk codes while busy.
    task automatic run_code(input logic [4:0] off, input logic [4:0] len, input logic [7:0] ch,
                            input bit noise);
        int bubbles = 0;
        bit early = 1'b0;
        wait_ready();
        bus.code_valid = 1'b1;
        bus.offset = off;
        bus.match_len = len;
        bus.char_nxt = ch;
        @(posedge clk);
        #1;
        bus.code_valid = 1'b0;
        @(negedge clk);
        if (noise && len != 5'd0) begin
            bus.code_valid = 1'b1;
            bus.offset = 5'($urandom);
            bus.match_len = 5'($urandom);
            bus.char_nxt = 8'($urandom);
        end
        for (int k = 0; k <= int'(len); k++) begin
            @(negedge clk);
            if (bus.out_valid) got_q.push_back(bus.char_out);
            else bubbles++;
            if (k < int'(len) && bus.code_ready) early = 1'b1;
            if (k == int'(len) - 1) bus.code_valid = 1'b0;
        end
        if (ch != END_CH) begin
            check("timing_bubbles", 32'(bubbles), 32'd0);
            check("timing_ready", {30'd0, early, bus.code_ready}, 32'd1);
        end
    endtask

    task automatic cmp_stream(input string name);
        check($sformatf("%s_count", name), 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s[%0d]", name, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        got_q = {};
        exp_q = {};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit         bad;
        logic [4:0] r_off;
        logic [4:0] r_len;
        logic [7:0] r_ch;

        vecs[0] = '{5'd0, 5'd0, 8'h01, 4'd1, 64'h01};
        vecs[1] = '{5'd0, 5'd0, 8'h02, 4'd1, 64'h02};
        vecs[2] = '{5'd0, 5'd0, 8'h03, 4'd1, 64'h03};
        vecs[3] = '{5'd2, 5'd3, 8'h04, 4'd4, 64'h04030201};
        vecs[4] = '{5'd0, 5'd0, 8'h05, 4'd1, 64'h05};
        vecs[5] = '{5'd0, 5'd5, 8'h06, 4'd6, 64'h060505050505};
        vecs[6] = '{5'd1, 5'd2, 8'h07, 4'd3, 64'h070605};
        vecs[7] = '{5'd4, 5'd1, 8'h08, 4'd2, 64'h0805};

        #2;
        do_reset();

        // Single literal: exact cycle of appearance and hold afterwards.
        bus.code_valid = 1'b1;
        bus.offset = 5'd0;
        bus.match_len = 5'd0;
        bus.char_nxt = 8'h03;
        @(posedge clk);
        #1;
        bus.code_valid = 1'b0;
        @(negedge clk);
        check("t1_gap_valid", 32'(bus.out_valid), 32'd0);
        check("t1_gap_ready", 32'(bus.code_ready), 32'd0);
        @(negedge clk);
        check("t1_valid", 32'(bus.out_valid), 32'd1);
        check("t1_char", 32'(bus.char_out), 32'h03);
        check("t1_ready", 32'(bus.code_ready), 32'd1);
        @(negedge clk);
        check("t1_after_valid", 32'(bus.out_valid), 32'd0);
        check("t1_hold_char", 32'(bus.char_out), 32'h03);

        foreach (vecs[i]) begin
            run_code(vecs[i].off, vecs[i].len, vecs[i].ch, 1'b0);
            for (int j = 0; j < int'(vecs[i].n); j++) exp_q.push_back(vecs[i].exp[8*j +: 8]);
            cmp_stream($sformatf("vec%0d", i));
        end
`ifdef LZ77_DEC_CHECK_EN
        check("legal_code_err", 32'(bus.code_err), 32'd0);
`endif

        // End marker, then codes offered after DONE must be ignored.
        run_code(5'd0, 5'd0, END_CH, 1'b0);
        check("end_finish", 32'(bus.finish), 32'd1);
        check("end_out_valid", 32'(bus.out_valid), 32'd0);
        check("end_ready", 32'(bus.code_ready), 32'd0);
        check("end_no_chars", 32'(got_q.size()), 32'd0);
        bus.code_valid = 1'b1;
        bus.offset = 5'd0;
        bus.match_len = 5'd0;
        bus.char_nxt = 8'h55;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.out_valid || bus.code_ready || !bus.finish) bad = 1'b1;
        end
        bus.code_valid = 1'b0;
        check("done_absorbing", 32'(bad), 32'd0);

        do_reset();
        for (int i = 0; i < 60; i++) begin
            r_off = 5'($urandom_range(0, 31));
            r_len = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(9, 31))
                                                : 5'($urandom_range(0, 8));
            r_ch  = 8'($urandom_range(0, 15));
            model_code(r_off, r_len, r_ch);
            run_code(r_off, r_len, r_ch, 1'($urandom_range(0, 1)));
            cmp_stream($sformatf("rnd%0d", i));
        end

        // Reset in the middle of a long copy.
        wait_ready();
        bus.code_valid = 1'b1;
        bus.offset = 5'd0;
        bus.match_len = 5'd24;
        bus.char_nxt = 8'h0b;
        @(posedge clk);
        #1;
        bus.code_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_copy_valid", 32'(bus.out_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_finish", 32'(bus.finish), 32'd0);
        check("mid_rst_ready", 32'(bus.code_ready), 32'd1);
        check("mid_rst_char", 32'(bus.char_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        run_code(5'd0, 5'd0, 8'h07, 1'b0);
        run_code(5'd1, 5'd1, 8'h09, 1'b0);
        exp_q = {8'h07, 8'h00, 8'h09};
        cmp_stream("post_rst");

`ifdef LZ77_DEC_CHECK_EN
        do_reset();
        run_code(5'd3, 5'd2, 8'h01, 1'b0);
        check("err_early_ref", 32'(bus.code_err), 32'd1);
        run_code(5'd0, 5'd0, 8'h05, 1'b0);
        check("err_sticky", 32'(bus.code_err), 32'd1);
        do_reset();
        run_code(5'd0, 5'd0, 8'h01, 1'b0);
        check("err_clean_literal", 32'(bus.code_err), 32'd0);
        run_code(5'd31, 5'd1, 8'h02, 1'b0);
        check("err_offset_range", 32'(bus.code_err), 32'd1);
        got_q = {};
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
